// File: rtl/npu_pkg.sv
// Shared NPU definitions: instruction word layout, instruction-queue state
// encoding and the host status word packer.
package npu_pkg;

  // Instruction word width and field positions.
  localparam int INST_W  = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 30;
  localparam int FUN_MSB = 29;
  localparam int FUN_LSB = 25;
  localparam int ARG_MSB = 24;
  localparam int ARG_LSB = 0;

  // Width of the occupancy field inside the host status word.
  localparam int STATUS_CNT_W = 7;

  // Instruction queue occupancy states.
  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_e;

  // Host status word: {overflow, full, empty, 22'b0, count[6:0]}.
  function automatic logic [31:0] pack_status(input logic                    ovf,
                                              input logic                    full,
                                              input logic                    empty,
                                              input logic [STATUS_CNT_W-1:0] cnt);
    return {ovf, full, empty, 22'b0, cnt};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO storage with wrapping pointers and a separate occupancy
// counter. Callers qualify push/pop: push only when space (or a same-cycle
// pop) exists, pop only when non-empty. clear discards every entry.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write port.
  // NOTE: the data array carries no reset; occupancy alone decides which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap modulo DEPTH (power of two); count tracks occupancy.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/inst_queue.sv
// Host-to-control-unit instruction queue. Wraps sync_fifo with push/pop
// qualification, flush, an EMPTY/PARTIAL/FULL control FSM and the host
// status word. Define INST_QUEUE_STATUS_EN to build the sticky overflow flag
// and the registered status word on f2h_io; otherwise f2h_io reads zero and
// writes to a full queue are still silently dropped.
module inst_queue
  import npu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = INST_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           h2f_io,
  input  logic                   h2f_write,
  input  logic                   flush,
  input  logic                   ovf_clr,
  output logic [W-1:0]           inst_data,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            f2h_io,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_LAST_IN = CW'(DEPTH - 1);

  q_state_e      state_q;
  q_state_e      state_d;
  logic [W-1:0]  fifo_dout;
  logic          pop_fire;
  logic          push_ok;
  logic          push_fire;

  // A pop frees a slot in the same cycle, so a full queue still accepts a
  // write that coincides with a pop. Flush suppresses both sides.
  assign inst_valid = (count != '0);
  assign pop_fire   = inst_valid && inst_ready && !flush;
  assign push_ok    = (state_q != Q_FULL) || pop_fire;
  assign push_fire  = h2f_write && push_ok && !flush;

  // Head is gated to zero when empty, which also holds it at zero in reset.
  assign inst_data = inst_valid ? fifo_dout : '0;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push_fire),
    .pop   (pop_fire),
    .din   (h2f_io),
    .dout  (fifo_dout),
    .count (count)
  );

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= Q_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state: only push-only or pop-only cycles move between states.
  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = Q_EMPTY;
    end else if (push_fire && !pop_fire) begin
      if (state_q == Q_EMPTY)         state_d = Q_PARTIAL;
      else if (count == CNT_LAST_IN)  state_d = Q_FULL;
    end else if (pop_fire && !push_fire) begin
      if (state_q == Q_FULL)          state_d = Q_PARTIAL;
      else if (count == CNT_ONE)      state_d = Q_EMPTY;
    end
  end

`ifdef INST_QUEUE_STATUS_EN
  logic overflow;
  logic drop;

  // A write the queue cannot take; a flushed write is discarded, not dropped.
  assign drop = h2f_write && !push_ok && !flush;

  // Sticky overflow flag; a same-cycle drop beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // Status word, registered so it trails the queue state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) f2h_io <= pack_status(1'b0, 1'b0, 1'b1, '0);
    else     f2h_io <= pack_status(overflow, state_q == Q_FULL,
                                   state_q == Q_EMPTY, STATUS_CNT_W'(count));
  end
`else
  logic unused_status;
  assign unused_status = ovf_clr;
  assign f2h_io        = 32'h0;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  h2f_io;
  logic          h2f_write;
  logic          flush;
  logic          ovf_clr;
  logic [W-1:0]  inst_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   f2h_io;
  logic [CW-1:0] count;

  inst_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .h2f_io     (h2f_io),
    .h2f_write  (h2f_write),
    .flush      (flush),
    .ovf_clr    (ovf_clr),
    .inst_data  (inst_data),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .f2h_io     (f2h_io),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [W-1:0] mq[$];
  bit           m_ovf;
  logic [31:0]  m_f2h;
  logic [W-1:0] last_out;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] f2h_reset_value();
`ifdef INST_QUEUE_STATUS_EN
    return 32'h2000_0000;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_f2h = f2h_reset_value();
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit wr, input logic [W-1:0] d, input bit fl,
                            input bit clr, input bit rdy);
    int sz;
    bit pop;
    bit ovf_set;
    sz      = mq.size();
    pop     = (sz != 0) && rdy && !fl;
    ovf_set = 1'b0;
`ifdef INST_QUEUE_STATUS_EN
    m_f2h = {m_ovf, sz == DEPTH, sz == 0, 22'b0, 7'(sz)};
`endif
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (wr) begin
        if (sz < DEPTH || pop) mq.push_back(d);
        else                   ovf_set = 1'b1;
      end
    end
    if (ovf_set)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".valid"}, 32'(inst_valid), 32'(mq.size() != 0));
    check({tag, ".data"},  inst_data, (mq.size() != 0) ? mq[0] : 32'h0);
    check({tag, ".f2h"},   f2h_io, m_f2h);
  endtask

  // One clock cycle: drive at negedge, step the model, check at next negedge.
  task automatic cycle(input string tag, input bit wr, input logic [W-1:0] d,
                       input bit fl, input bit clr, input bit rdy);
    h2f_write  = wr;
    h2f_io     = d;
    flush      = fl;
    ovf_clr    = clr;
    inst_ready = rdy;
    if (inst_valid && rdy && !fl) last_out = inst_data;
    model_step(wr, d, fl, clr, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; h2f_io = '0; h2f_write = 1'b0; flush = 1'b0;
    ovf_clr = 1'b0; inst_ready = 1'b0; last_out = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    idle("post_reset");

    // Two writes with the control unit stalled: head held, count 2.
    cycle("w1", 1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b0);
    cycle("w2", 1'b1, 32'hA000_0002, 1'b0, 1'b0, 1'b0);
    idle("hold1");
    check("two_count", 32'(count), 32'd2);
    check("two_head", inst_data, 32'hA000_0001);
    idle("hold2");
    check("two_head_stable", inst_data, 32'hA000_0001);
`ifdef INST_QUEUE_STATUS_EN
    check("two_f2h", f2h_io, 32'h0000_0002);
`else
    check("two_f2h", f2h_io, 32'h0);
`endif

    // Nine writes into an eight-deep queue: ninth dropped.
    cycle("flush0", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) cycle("fill9", 1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("nine_count", 32'(count), 32'd8);
    idle("nine_idle");
`ifdef INST_QUEUE_STATUS_EN
    check("nine_ovf_full", 32'(f2h_io[31:30]), 32'h3);
`endif
    for (int i = 0; i < 8; i++) cycle("drain9", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("nine_last_out", last_out, 32'hB000_0008);
    check("nine_empty", 32'(inst_valid), 32'h0);

    // Full queue with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) cycle("fill8", 1'b1, 32'hC000_0000 + 32'(i), 1'b0, i == 1, 1'b0);
    cycle("pushpop", 1'b1, 32'hC000_0009, 1'b0, 1'b0, 1'b1);
    check("pushpop_count", 32'(count), 32'd8);
    check("pushpop_head", inst_data, 32'hC000_0002);
    idle("pushpop_idle");
`ifdef INST_QUEUE_STATUS_EN
    check("pushpop_no_ovf", 32'(f2h_io[31]), 32'h0);
`endif
    for (int i = 0; i < 8; i++) cycle("drain_pp", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("pushpop_last_out", last_out, 32'hC000_0009);

    // Flush beats a same-cycle write.
    for (int i = 1; i <= 5; i++) cycle("fill5", 1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle("flush_wr", 1'b1, 32'hD000_00FF, 1'b1, 1'b0, 1'b0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(inst_valid), 32'h0);
    idle("flush_idle");
`ifdef INST_QUEUE_STATUS_EN
    check("flush_f2h", f2h_io, 32'h2000_0000);
`else
    check("flush_f2h", f2h_io, 32'h0);
`endif

    // Overflow set wins over clear; clear alone then drops it.
    for (int i = 1; i <= 8; i++) cycle("fill_ovf", 1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle("ovf_set", 1'b1, 32'h5000_0009, 1'b0, 1'b0, 1'b0);
    cycle("ovf_clr_wr", 1'b1, 32'h5000_000A, 1'b0, 1'b1, 1'b0);
    idle("ovf_idle1");
`ifdef INST_QUEUE_STATUS_EN
    check("ovf_set_wins", 32'(f2h_io[31]), 32'h1);
`endif
    cycle("ovf_clr", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle("ovf_idle2");
`ifdef INST_QUEUE_STATUS_EN
    check("ovf_cleared", 32'(f2h_io[31]), 32'h0);
`endif

    // Asynchronous reset mid-transfer.
    cycle("flush1", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) cycle("fill3", 1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    h2f_write = 1'b1; h2f_io = 32'hE000_0004; flush = 1'b0; ovf_clr = 1'b0; inst_ready = 1'b1;
    model_step(1'b1, 32'hE000_0004, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(inst_valid), 32'h0);
    check("arst_data", inst_data, 32'h0);
    check("arst_f2h", f2h_io, f2h_reset_value());
    h2f_write = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle("after_rst", 1'b1, 32'hF000_0001, 1'b0, 1'b0, 1'b0);
    check("after_rst_data", inst_data, 32'hF000_0001);
    check("after_rst_valid", 32'(inst_valid), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle("rand",
            $urandom_range(0, 99) < 60,
            $urandom,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
